mips_instr_encoder: RTL

- Encoder counterpart of the pipeline's instruction control decoder: turns a symbolic operation request (op select plus register, shift, immediate and target fields) into a 32-bit MIPS instruction word.
- Feeds the instruction-memory loader and self-test stimulus path: each word is emitted with its target byte address over a valid/ready stream, behind a 2-entry skid buffer.
- Covers exactly the instruction set the decoder accepts, so decoder(encoder(x)) round-trips.

---
 rtl/mips_instr_encoder_pkg.sv | 88 ++++++++
 rtl/mips_instr_encoder_pack.sv | 116 +++++++++++
 rtl/mips_instr_encoder.sv | 115 +++++++++++
 3 files changed

// File: rtl/mips_instr_encoder_pkg.sv
// mips_instr_encoder_pkg
// Shared definitions for the MIPS instruction encoder:
//   - op_e        : symbolic op select; its order is the request encoding on in_op
//   - OP_COUNT    : number of legal op selects, any in_op >= OP_COUNT is illegal
//   - OPC_* / FN_*: primary opcode and SPECIAL funct values (mips.h numbering)
//   - *_LSB       : bit positions of the instruction word fields
package mips_instr_encoder_pkg;

    typedef enum logic [4:0] {
        OP_ADD     = 5'd0,
        OP_ADDU    = 5'd1,
        OP_AND     = 5'd2,
        OP_DIV     = 5'd3,
        OP_MFHI    = 5'd4,
        OP_MFLO    = 5'd5,
        OP_JR      = 5'd6,
        OP_OR      = 5'd7,
        OP_SLL     = 5'd8,
        OP_SRA     = 5'd9,
        OP_SLT     = 5'd10,
        OP_SUB     = 5'd11,
        OP_SYSCALL = 5'd12,
        OP_ADDI    = 5'd13,
        OP_ADDIU   = 5'd14,
        OP_ANDI    = 5'd15,
        OP_ORI     = 5'd16,
        OP_LUI     = 5'd17,
        OP_LW      = 5'd18,
        OP_SW      = 5'd19,
        OP_SB      = 5'd20,
        OP_BEQ     = 5'd21,
        OP_BNE     = 5'd22,
        OP_BLTZ    = 5'd23,
        OP_J       = 5'd24,
        OP_JAL     = 5'd25
    } op_e;

    localparam int OP_COUNT = 26;

    // Instruction word layout class used when assembling the final word.
    typedef enum logic [1:0] {
        FMT_R = 2'd0,
        FMT_I = 2'd1,
        FMT_J = 2'd2
    } fmt_e;

    // Primary opcodes.
    localparam logic [5:0] OPC_SPECIAL = 6'h00;
    localparam logic [5:0] OPC_REGIMM  = 6'h01;
    localparam logic [5:0] OPC_J       = 6'h02;
    localparam logic [5:0] OPC_JAL     = 6'h03;
    localparam logic [5:0] OPC_BEQ     = 6'h04;
    localparam logic [5:0] OPC_BNE     = 6'h05;
    localparam logic [5:0] OPC_ADDI    = 6'h08;
    localparam logic [5:0] OPC_ADDIU   = 6'h09;
    localparam logic [5:0] OPC_ANDI    = 6'h0C;
    localparam logic [5:0] OPC_ORI     = 6'h0D;
    localparam logic [5:0] OPC_LUI     = 6'h0F;
    localparam logic [5:0] OPC_LW      = 6'h23;
    localparam logic [5:0] OPC_SB      = 6'h28;
    localparam logic [5:0] OPC_SW      = 6'h2B;

    // SPECIAL funct codes.
    localparam logic [5:0] FN_SLL      = 6'h00;
    localparam logic [5:0] FN_SRA      = 6'h03;
    localparam logic [5:0] FN_JR       = 6'h08;
    localparam logic [5:0] FN_SYSCALL  = 6'h0C;
    localparam logic [5:0] FN_MFHI     = 6'h10;
    localparam logic [5:0] FN_MFLO     = 6'h12;
    localparam logic [5:0] FN_DIV      = 6'h1A;
    localparam logic [5:0] FN_ADD      = 6'h20;
    localparam logic [5:0] FN_ADDU     = 6'h21;
    localparam logic [5:0] FN_SUB      = 6'h22;
    localparam logic [5:0] FN_AND      = 6'h24;
    localparam logic [5:0] FN_OR       = 6'h25;
    localparam logic [5:0] FN_SLT      = 6'h2A;

    // BLTZ is REGIMM with this value in the rt slot.
    localparam logic [4:0] RT_BLTZ     = 5'd0;

    // Field positions inside the 32-bit word.
    localparam int OPC_LSB   = 26;
    localparam int RS_LSB    = 21;
    localparam int RT_LSB    = 16;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_LSB = 6;

endpackage

// File: rtl/mips_instr_encoder_pack.sv
// mips_instr_pack
// Purely combinational encoder: op select plus operand fields -> 32-bit MIPS
// instruction word. Fields an instruction does not use are forced to zero so
// the word matches what the decoder expects to see.
// Ports:
//   op      : op select (op_e encoding), values >= OP_COUNT are illegal
//   rs/rt/rd/shamt : register and shift fields
//   imm     : 16-bit immediate / branch offset
//   target  : 26-bit jump target
//   instr   : encoded word (0 when illegal)
//   legal   : high when op is a known op select
module mips_instr_pack
    import mips_instr_encoder_pkg::*;
(
    input  logic [4:0]  op,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [25:0] target,
    output logic [31:0] instr,
    output logic        legal
);

    fmt_e       fmt;
    logic [5:0] opc;
    logic [5:0] fn;
    logic [4:0] f_rs;
    logic [4:0] f_rt;
    logic [4:0] f_rd;
    logic [4:0] f_sh;

    // Per-op field selection; defaults describe a plain three-register R-type.
    always_comb begin
        fmt   = FMT_R;
        opc   = OPC_SPECIAL;
        fn    = 6'h00;
        f_rs  = rs;
        f_rt  = rt;
        f_rd  = rd;
        f_sh  = 5'd0;
        legal = 1'b1;
        case (op)
            OP_ADD:     fn = FN_ADD;
            OP_ADDU:    fn = FN_ADDU;
            OP_AND:     fn = FN_AND;
            OP_OR:      fn = FN_OR;
            OP_SLT:     fn = FN_SLT;
            OP_SUB:     fn = FN_SUB;
            OP_DIV: begin
                fn   = FN_DIV;
                f_rd = 5'd0;
            end
            OP_MFHI, OP_MFLO: begin
                fn   = (op == OP_MFHI) ? FN_MFHI : FN_MFLO;
                f_rs = 5'd0;
                f_rt = 5'd0;
            end
            OP_JR: begin
                fn   = FN_JR;
                f_rt = 5'd0;
                f_rd = 5'd0;
            end
            OP_SLL, OP_SRA: begin
                fn   = (op == OP_SLL) ? FN_SLL : FN_SRA;
                f_rs = 5'd0;
                f_sh = shamt;
            end
            OP_SYSCALL: begin
                fn   = FN_SYSCALL;
                f_rs = 5'd0;
                f_rt = 5'd0;
                f_rd = 5'd0;
            end
            OP_ADDI:  begin fmt = FMT_I; opc = OPC_ADDI;  end
            OP_ADDIU: begin fmt = FMT_I; opc = OPC_ADDIU; end
            OP_ANDI:  begin fmt = FMT_I; opc = OPC_ANDI;  end
            OP_ORI:   begin fmt = FMT_I; opc = OPC_ORI;   end
            OP_LW:    begin fmt = FMT_I; opc = OPC_LW;    end
            OP_SW:    begin fmt = FMT_I; opc = OPC_SW;    end
            OP_SB:    begin fmt = FMT_I; opc = OPC_SB;    end
            OP_BEQ:   begin fmt = FMT_I; opc = OPC_BEQ;   end
            OP_BNE:   begin fmt = FMT_I; opc = OPC_BNE;   end
            OP_LUI: begin
                fmt  = FMT_I;
                opc  = OPC_LUI;
                f_rs = 5'd0;
            end
            OP_BLTZ: begin
                fmt  = FMT_I;
                opc  = OPC_REGIMM;
                f_rt = RT_BLTZ;
            end
            OP_J:     begin fmt = FMT_J; opc = OPC_J;     end
            OP_JAL:   begin fmt = FMT_J; opc = OPC_JAL;   end
            default:  legal = 1'b0;
        endcase
    end

    // Final word assembly by layout class.
    always_comb begin
        instr = 32'd0;
        if (legal) begin
            case (fmt)
                FMT_R: instr = (32'(opc)  << OPC_LSB) | (32'(f_rs) << RS_LSB) |
                               (32'(f_rt) << RT_LSB)  | (32'(f_rd) << RD_LSB) |
                               (32'(f_sh) << SHAMT_LSB) | 32'(fn);
                FMT_I: instr = (32'(opc)  << OPC_LSB) | (32'(f_rs) << RS_LSB) |
                               (32'(f_rt) << RT_LSB)  | 32'(imm);
                default: instr = (32'(opc) << OPC_LSB) | 32'(target);
            endcase
        end
    end

endmodule

// File: rtl/mips_instr_encoder.sv
// mips_instr_encoder
// Encodes symbolic operation requests into MIPS words and streams each word
// with its byte address through a 2-entry FIFO (head drives out_*).
// Ports:
//   clk, rst_b          : clock, asynchronous active-low reset
//   in_valid/in_ready   : request handshake
//   in_op..in_target    : op select and operand fields
//   addr_load/addr_value: reload of the emit address counter (low 2 bits ignored)
//   out_valid/out_ready : word handshake
//   out_instr/out_addr  : head word and its byte address
//   err_illegal         : sticky flag, an illegal op select was accepted
//   emit_count          : number of words handed out, wraps
module mips_instr_encoder
    import mips_instr_encoder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0040_0000,
    parameter logic [31:0] ADDR_STEP = 32'd4
)(
    input  logic        clk,
    input  logic        rst_b,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [4:0]  in_op,
    input  logic [4:0]  in_rs,
    input  logic [4:0]  in_rt,
    input  logic [4:0]  in_rd,
    input  logic [4:0]  in_shamt,
    input  logic [15:0] in_imm,
    input  logic [25:0] in_target,
    input  logic        addr_load,
    input  logic [31:0] addr_value,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_addr,
    output logic        err_illegal,
    output logic [15:0] emit_count
);

    logic [31:0] pack_instr;
    logic        pack_legal;
    logic [31:0] mem_instr [2];
    logic [31:0] mem_addr  [2];
    logic [1:0]  count;
    logic        wr_ptr;
    logic        rd_ptr;
    logic        started;
    logic [31:0] addr_cnt;
    logic [31:0] cur_addr;
    logic        accept;
    logic        push;
    logic        pop;

    mips_instr_pack u_pack (
        .op     (in_op),
        .rs     (in_rs),
        .rt     (in_rt),
        .rd     (in_rd),
        .shamt  (in_shamt),
        .imm    (in_imm),
        .target (in_target),
        .instr  (pack_instr),
        .legal  (pack_legal)
    );

    // started keeps in_ready low until the first edge after reset release.
    assign in_ready  = started && (count != 2'd2);
    assign out_valid = (count != 2'd0);
    assign out_instr = mem_instr[rd_ptr];
    assign out_addr  = mem_addr[rd_ptr];

    assign accept = in_valid && in_ready;
    assign push   = accept && pack_legal;
    assign pop    = out_valid && out_ready;

    // A load in the same cycle as an accept overrides the counter for that word.
    assign cur_addr = addr_load ? (addr_value & ~32'd3) : addr_cnt;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            started     <= 1'b0;
            count       <= 2'd0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            addr_cnt    <= BASE_ADDR;
            err_illegal <= 1'b0;
            emit_count  <= 16'd0;
            for (int i = 0; i < 2; i++) begin
                mem_instr[i] <= 32'd0;
                mem_addr[i]  <= BASE_ADDR;
            end
        end else begin
            started <= 1'b1;
            if (push) begin
                mem_instr[wr_ptr] <= pack_instr;
                mem_addr[wr_ptr]  <= cur_addr;
                wr_ptr            <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr     <= ~rd_ptr;
                emit_count <= emit_count + 16'd1;
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            addr_cnt <= push ? (cur_addr + ADDR_STEP) : cur_addr;
            if (accept && !pack_legal) begin
                err_illegal <= 1'b1;
            end
        end
    end

endmodule
